// File: rtl/pipeline_core_fwd.sv
// 5-stage in-order core (IF/ID/EX/MEM/WB): instruction at PC k retires 4 cycles after fetch.
// Full EX/MEM + MEM/WB forwarding; load-use holds IF/ID for one cycle; HALT freezes fetch and drains.
module pipeline_core_fwd #(
  parameter int DATA_W  = 8,
  parameter int NREG    = 16,
  parameter int PC_W    = 4,
  parameter int DADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_instr,
  output logic [DADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               wb_valid,
  output logic [3:0]         wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               halted
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_LOAD  = 4'h3,
    OP_STORE = 4'h4,
    OP_ADDI  = 4'h5,
    OP_HALT  = 4'hF
  } op_t;

  typedef struct packed {
    logic        vld;
    logic [15:0] instr;
  } ifid_t;

  typedef struct packed {
    logic              vld;
    op_t               op;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] imm;
  } idex_t;

  typedef struct packed {
    logic              vld;
    op_t               op;
    logic [3:0]        rd;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] sdat;
  } exmem_t;

  typedef struct packed {
    logic              vld;
    op_t               op;
    logic [3:0]        rd;
    logic [DATA_W-1:0] dat;
  } memwb_t;

  logic [PC_W-1:0]   pc;
  ifid_t             ifid;
  idex_t             idex, id_next;
  exmem_t            exmem, ex_next;
  memwb_t            memwb, mem_next;
  logic              fetch_stop;
  logic [DATA_W-1:0] rf [NREG];

  function automatic op_t decode(input logic [3:0] opc);
    case (opc)
      4'h1:    return OP_ADD;
      4'h2:    return OP_SUB;
      4'h3:    return OP_LOAD;
      4'h4:    return OP_STORE;
      4'h5:    return OP_ADDI;
      4'hF:    return OP_HALT;
      default: return OP_NOP;
    endcase
  endfunction

  function automatic logic wr_op(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD) || (op == OP_ADDI);
  endfunction

  // ---------------- ID: decode, register read (write-through), interlock
  op_t        id_op;
  logic [3:0] id_rd, id_rs1, id_rs2;
  logic       use_rs1, use_rs2, use_rd;
  logic       wb_we, load_hit, stall, id_halt;

  assign wb_we = memwb.vld && wr_op(memwb.op) && (memwb.rd != 4'd0);

  function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] idx);
    if (idx == 4'd0) return '0;
    if (wb_we && (memwb.rd == idx)) return memwb.dat;
    return rf[idx];
  endfunction

  always_comb begin
    id_op   = ifid.vld ? decode(ifid.instr[15:12]) : OP_NOP;
    id_rd   = ifid.instr[11:8];
    id_rs1  = ifid.instr[7:4];
    id_rs2  = ifid.instr[3:0];
    use_rs1 = (id_op == OP_ADD) || (id_op == OP_SUB) || (id_op == OP_LOAD) ||
              (id_op == OP_STORE) || (id_op == OP_ADDI);
    use_rs2 = (id_op == OP_ADD) || (id_op == OP_SUB);
    use_rd  = (id_op == OP_STORE);
    id_halt = (id_op == OP_HALT);

    load_hit = idex.vld && (idex.op == OP_LOAD) && (idex.rd != 4'd0);
    stall    = load_hit && ((use_rs1 && (id_rs1 == idex.rd)) ||
                            (use_rs2 && (id_rs2 == idex.rd)) ||
                            (use_rd  && (id_rd  == idex.rd)));

    id_next     = '0;
    id_next.vld = ifid.vld;
    id_next.op  = id_op;
    id_next.rd  = id_rd;
    id_next.rs1 = id_rs1;
    id_next.rs2 = id_rs2;
    id_next.a   = rd_reg(id_rs1);
    id_next.b   = rd_reg(id_rs2);
    id_next.s   = rd_reg(id_rd);
    id_next.imm = DATA_W'(ifid.instr[3:0]);
  end

  // ---------------- EX: operand forwarding and ALU
  // A LOAD sitting in EX/MEM has no data yet; the interlock guarantees nobody needs it here.
  function automatic logic [DATA_W-1:0] fwd(input logic [3:0] idx, input logic [DATA_W-1:0] regval);
    if ((idx != 4'd0) && exmem.vld && wr_op(exmem.op) && (exmem.op != OP_LOAD) && (exmem.rd == idx))
      return exmem.res;
    if ((idx != 4'd0) && memwb.vld && wr_op(memwb.op) && (memwb.rd == idx))
      return memwb.dat;
    return regval;
  endfunction

  logic [DATA_W-1:0] ex_a, ex_b, ex_s, ex_res;

  always_comb begin
    ex_a = fwd(idex.rs1, idex.a);
    ex_b = fwd(idex.rs2, idex.b);
    ex_s = fwd(idex.rd, idex.s);
    case (idex.op)
      OP_ADD:                    ex_res = ex_a + ex_b;
      OP_SUB:                    ex_res = ex_a - ex_b;
      OP_LOAD, OP_STORE, OP_ADDI: ex_res = ex_a + idex.imm;
      default:                   ex_res = '0;
    endcase
    ex_next      = '0;
    ex_next.vld  = idex.vld;
    ex_next.op   = idex.op;
    ex_next.rd   = idex.rd;
    ex_next.res  = ex_res;
    ex_next.sdat = ex_s;
  end

  // ---------------- MEM
  always_comb begin
    mem_next     = '0;
    mem_next.vld = exmem.vld;
    mem_next.op  = exmem.op;
    mem_next.rd  = exmem.rd;
    mem_next.dat = (exmem.op == OP_LOAD) ? dmem_rdata : exmem.res;
  end

  assign imem_addr  = pc;
  assign dmem_addr  = DADDR_W'(exmem.res);
  assign dmem_we    = exmem.vld && (exmem.op == OP_STORE);
  assign dmem_wdata = exmem.sdat;
  assign wb_valid   = memwb.vld && wr_op(memwb.op);
  assign wb_rd      = wb_valid ? memwb.rd  : 4'd0;
  assign wb_data    = wb_valid ? memwb.dat : '0;

  // ---------------- pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      ifid       <= '0;
      idex       <= '0;
      exmem      <= '0;
      memwb      <= '0;
      fetch_stop <= 1'b0;
      halted     <= 1'b0;
    end else begin
      if (!stall && !fetch_stop && !id_halt)
        pc <= pc + PC_W'(1);
      if (!stall) begin
        if (fetch_stop || id_halt) begin
          ifid <= '0;
        end else begin
          ifid.vld   <= 1'b1;
          ifid.instr <= imem_instr;
        end
      end
      idex  <= stall ? '0 : id_next;
      exmem <= ex_next;
      memwb <= mem_next;
      if (id_halt && !stall)
        fetch_stop <= 1'b1;
      if (memwb.vld && (memwb.op == OP_HALT))
        halted <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (wb_we) begin
      rf[memwb.rd] <= memwb.dat;
    end
  end

endmodule
